input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Parametrised N-channel front end for asynchronous pad inputs (buttons, switch data).
//  Per channel: multi-stage synchronizer, then a debounce filter, then a one-cycle
//  rise/fall pulse generator. Replaces the ad-hoc per-bit synchronizer bank at chip
//  top. Core logic receives clean levels plus single-cycle Next/Done-style strobes.
// PARAMETERS
//  NUM_CH          6  number of independent input channels
//  SYNC_STAGES     2  synchronizer flops per channel (>=2)
//  DEBOUNCE_CYCLES 4  consecutive stable cycles needed to accept a new level (>=1)
// PORTS
//  clock       in   1       single system clock
//  reset       in   1       asynchronous, active-high reset
//  async_in    in   NUM_CH  raw pad inputs, asynchronous to clock
//  enable      in   1       1 = filter runs; 0 = accepted levels frozen
//  level_out   out  NUM_CH  debounced, synchronous level per channel
//  rise_pulse  out  NUM_CH  1-cycle strobe when level_out[i] goes 0->1
//  fall_pulse  out  NUM_CH  1-cycle strobe when level_out[i] goes 1->0
//  changed     out  1       |(rise_pulse | fall_pulse), same cycle
// BEHAVIOUR
//  - reset: all sync flops, counters, level_out, rise_pulse, fall_pulse, changed -> 0,
//    asynchronously, including mid-debounce; no pulse is produced on reset release.
//  - Sync: sync[i] = async_in[i] delayed through SYNC_STAGES flops; runs regardless of enable.
//  - Debounce per channel: counter cnt[i], width $clog2(DEBOUNCE_CYCLES+1).
//    enable=1, sync[i]==level_out[i]: cnt<=0.
//    enable=1, sync[i]!=level_out[i], cnt==DEBOUNCE_CYCLES-1: level_out<=sync, cnt<=0.
//    enable=1, sync[i]!=level_out[i], otherwise: cnt<=cnt+1.
//    enable=0: cnt<=0, level_out holds, pulses 0.
//  - A glitch shorter than DEBOUNCE_CYCLES sync cycles never reaches level_out;
//    a returning level clears cnt (no accumulation across glitches).
//  - Pulses are registered: asserted in exactly the cycle level_out first shows the
//    new value, deasserted the next cycle. Never both rise and fall for one channel.
//  - Latency: async edge captured at edge 0 -> level_out/pulse change after edge
//    SYNC_STAGES+DEBOUNCE_CYCLES-1 (defaults: visible 5 cycles after capture).
//  - Channels fully independent; simultaneous transitions on several channels all pulse
//    in the same cycle; changed is asserted once for that cycle.
//  - enable falling mid-count discards progress; re-enable restarts count from 0.
// STRUCTURE
//  - Package conditioner_pkg: default parameter constants, cnt width function.
//  - Sub-module debounce_channel (one channel: sync chain + counter + edge regs),
//    instantiated NUM_CH times via generate; top ORs pulses into changed.
//  - No combinational path from async_in to any output.
// TESTING (defaults unless stated; cycle 0 = first edge sampling the new value)
//  1. Clean rise on ch1, held high -> level_out[1]=1 and rise_pulse=6'b000010 only at
//     edge 5; changed=1 that cycle; all zero pulses at edge 6.
//  2. Bounce: ch0 high 3 cycles, low 2, high 3, low -> level_out[0] stays 0, no pulses;
//     then high held -> rise_pulse[0] at 5 edges after the final rise.
//  3. Simultaneous: with level_out=6'b000010, drive async_in=6'b111100 in one cycle ->
//     same cycle rise_pulse=6'b111100, fall_pulse=6'b000010, changed=1, level_out=6'b111100.
//  4. enable=0, ch3 rises and holds 10 cycles -> no level change/pulse; enable=1 ->
//     level_out[3]=1 with rise_pulse[3] exactly DEBOUNCE_CYCLES edges later.
//  5. Reset asserted 2 cycles into a ch4 count, with level_out=6'b010000 -> all outputs 0
//     immediately (before next edge); release with inputs low -> no pulses.
//  6. NUM_CH=1, SYNC_STAGES=3, DEBOUNCE_CYCLES=1 -> rise visible at edge 3; 1-cycle
//     glitch on sync output still accepted (filter depth 1).

Source files
------------

// File: rtl/conditioner_pkg.sv
// Shared defaults and helpers for the pad-input conditioning front end.
// Imported by the per-channel debounce block and the channel-bank top.
package conditioner_pkg;

  localparam int DEF_NUM_CH          = 6;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  // Per-cycle decision taken by a channel's debounce filter
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_IDLE   = 2'd1,
    ACT_COUNT  = 2'd2,
    ACT_ACCEPT = 2'd3
  } deb_action_e;

  // Counter must reach DEBOUNCE_CYCLES-1; never narrower than one bit
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: synchronizer chain, stability counter and
// registered rise/fall strobes that coincide with the level update.
module debounce_channel
  import conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  input  logic enable,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_pipe_p0;
  logic                   sync_bit;
  logic [CW-1:0]          cnt_p1;
  logic [CW-1:0]          cnt_next;
  logic                   level_next;
  deb_action_e            action;

  // Stage p0: metastability chain, free-running regardless of enable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_pipe_p0 <= '0;
    end else begin
      sync_pipe_p0 <= {sync_pipe_p0[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_bit = sync_pipe_p0[SYNC_STAGES-1];

  always_comb begin
    action     = ACT_HOLD;
    cnt_next   = '0;
    level_next = level_out;
    if (!enable) begin
      action = ACT_HOLD;
    end else if (sync_bit == level_out) begin
      action = ACT_IDLE;
    end else if (cnt_p1 == CNT_LAST) begin
      action = ACT_ACCEPT;
    end else begin
      action = ACT_COUNT;
    end

    case (action)
      ACT_COUNT:  cnt_next   = cnt_p1 + 1'b1;
      ACT_ACCEPT: level_next = sync_bit;
      ACT_IDLE:   cnt_next   = '0;
      ACT_HOLD:   cnt_next   = '0;
      default:    cnt_next   = '0;
    endcase
  end

  // Stage p1: accepted level with strobes registered on the same edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_p1     <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      cnt_p1     <= cnt_next;
      level_out  <= level_next;
      rise_pulse <= level_next & ~level_out;
      fall_pulse <= ~level_next & level_out;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// N-channel pad-input front end: independent synchronize/debounce/edge
// channels plus a combined strobe that fires when any channel moved.
module input_conditioner
  import conditioner_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] async_in,
  input  logic              enable,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic              changed
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .async_in  (async_in[ch]),
      .enable    (enable),
      .level_out (level_out[ch]),
      .rise_pulse(rise_pulse[ch]),
      .fall_pulse(fall_pulse[ch])
    );
  end

  // Built only from registered strobes, so async_in never reaches it directly
  assign changed = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed vector table, hand sequences and
// randomized traffic against a sliding-window reference model.
module tb_input_conditioner;

  localparam int S = 2;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] async_in;
  logic       enable;
  logic [5:0] level_out, rise_pulse, fall_pulse;
  logic       changed;

  logic [0:0] async2, level2, rise2, fall2;
  logic       changed2;

  int checks;
  int failures;

  always #5 clock = ~clock;

  input_conditioner dut (
    .clock(clock), .reset(reset), .async_in(async_in), .enable(enable),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .changed(changed)
  );

  input_conditioner #(.NUM_CH(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut2 (
    .clock(clock), .reset(reset), .async_in(async2), .enable(enable),
    .level_out(level2), .rise_pulse(rise2), .fall_pulse(fall2),
    .changed(changed2)
  );

  // Reference model: a level flips once the last D edges all saw the
  // synchronized input disagree with it while enabled.
  logic [5:0] hist_a [$];
  logic [5:0] seen_q [$];
  bit         en_q   [$];
  logic [5:0] m_level, m_rise, m_fall;

  task automatic model_reset();
    hist_a.delete(); seen_q.delete(); en_q.delete();
    for (int j = 0; j < S; j++) hist_a.push_back(6'b0);
    for (int j = 0; j < D; j++) begin
      seen_q.push_back(6'b0);
      en_q.push_back(1'b0);
    end
    m_level = '0; m_rise = '0; m_fall = '0;
  endtask

  task automatic model_edge(input logic [5:0] a, input logic e);
    logic [5:0] nl;
    bit all_diff;
    seen_q.push_front(hist_a[S-1]); void'(seen_q.pop_back());
    en_q.push_front(e);             void'(en_q.pop_back());
    hist_a.push_front(a);           void'(hist_a.pop_back());
    nl = m_level;
    for (int i = 0; i < 6; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++)
        if (!en_q[j] || (seen_q[j][i] == m_level[i])) all_diff = 1'b0;
      if (all_diff) nl[i] = ~m_level[i];
    end
    m_rise  = nl & ~m_level;
    m_fall  = ~nl & m_level;
    m_level = nl;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, clock once, compare against the model at the next falling edge
  task automatic step(input logic [5:0] a, input logic e, input logic a2);
    async_in = a; enable = e; async2 = a2;
    @(posedge clock);
    model_edge(a, e);
    @(negedge clock);
    check("model", {13'b0, level_out, rise_pulse, fall_pulse, changed},
          {13'b0, m_level, m_rise, m_fall, |(m_rise | m_fall)});
  endtask

  typedef struct {
    logic [5:0] a;
    logic       en;
    logic [5:0] exp_level;
    logic [5:0] exp_rise;
    logic [5:0] exp_fall;
    logic       exp_changed;
  } vec_t;

  vec_t vecs [14];
  logic [5:0] cur_a;
  logic       cur_en;

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; enable = 1'b0; async_in = '0; async2 = '0;
    model_reset();

    for (int k = 0; k < 14; k++) begin
      vecs[k].en = 1'b1;
      vecs[k].a  = (k < 7) ? 6'b000010 : 6'b111100;
      vecs[k].exp_level   = (k < 5) ? 6'b000000 : ((k < 12) ? 6'b000010 : 6'b111100);
      vecs[k].exp_rise    = 6'b0;
      vecs[k].exp_fall    = 6'b0;
      vecs[k].exp_changed = 1'b0;
    end
    vecs[5].exp_rise  = 6'b000010; vecs[5].exp_changed  = 1'b1;
    vecs[12].exp_rise = 6'b111100; vecs[12].exp_fall    = 6'b000010;
    vecs[12].exp_changed = 1'b1;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_state", {13'b0, level_out, rise_pulse, fall_pulse, changed}, 32'd0);
    check("reset_state2", {29'b0, level2, rise2, fall2}, 32'd0);
    reset = 1'b0;

    // Clean single rise, then simultaneous multi-channel change
    for (int k = 0; k < 14; k++) begin
      step(vecs[k].a, vecs[k].en, 1'b0);
      check($sformatf("vec%0d", k),
            {13'b0, level_out, rise_pulse, fall_pulse, changed},
            {13'b0, vecs[k].exp_level, vecs[k].exp_rise, vecs[k].exp_fall, vecs[k].exp_changed});
    end

    // Bounce on ch0: hi3 lo2 hi3 lo2 must be rejected
    for (int k = 0; k < 10; k++) begin
      cur_a = 6'b111100;
      cur_a[0] = (k < 3) || (k >= 5 && k < 8);
      step(cur_a, 1'b1, 1'b0);
      check($sformatf("bounce%0d", k), {26'b0, rise_pulse[0], fall_pulse[0], level_out[0], changed}, 32'd0);
    end
    for (int k = 0; k < 8; k++) begin
      step(6'b111101, 1'b1, 1'b0);
      check($sformatf("bounce_hold%0d", k), {30'b0, level_out[0], rise_pulse[0]},
            {30'b0, 1'(k >= 5), 1'(k == 5)});
    end

    repeat (8) step(6'b000000, 1'b1, 1'b0);

    // Disabled filter freezes ch3, then counts only once re-enabled
    for (int k = 0; k < 10; k++) begin
      step(6'b001000, 1'b0, 1'b0);
      check($sformatf("frozen%0d", k), {13'b0, level_out, rise_pulse, fall_pulse, changed}, 32'd0);
    end
    for (int k = 0; k < 5; k++) begin
      step(6'b001000, 1'b1, 1'b0);
      check($sformatf("reenable%0d", k), {20'b0, level_out, rise_pulse},
            {20'b0, (k >= 3) ? 6'b001000 : 6'b0, (k == 3) ? 6'b001000 : 6'b0});
    end

    // Reset mid-count on ch4 with level 010000
    repeat (8) step(6'b010000, 1'b1, 1'b0);
    repeat (4) step(6'b000000, 1'b1, 1'b0);
    check("pre_reset_level", {26'b0, level_out}, {26'b0, 6'b010000});
    reset = 1'b1;
    #1;
    check("async_reset", {13'b0, level_out, rise_pulse, fall_pulse, changed}, 32'd0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(6'b000000, 1'b1, 1'b0);
      check($sformatf("post_reset%0d", k), {13'b0, level_out, rise_pulse, fall_pulse, changed}, 32'd0);
    end

    // Shallow instance: 3 sync stages, single-cycle filter
    for (int k = 0; k < 5; k++) begin
      step(6'b000000, 1'b1, 1'b1);
      check($sformatf("d1_rise%0d", k), {29'b0, level2, rise2, changed2},
            {29'b0, 1'(k >= 3), 1'(k == 3), 1'(k == 3)});
    end
    for (int g = 0; g < 6; g++) begin
      step(6'b000000, 1'b1, (g == 0) ? 1'b0 : 1'b1);
      check($sformatf("d1_glitch%0d", g), {29'b0, level2, rise2, fall2},
            {29'b0, 1'(g != 3), 1'(g == 4), 1'(g == 3)});
    end

    // Randomized traffic with held levels, glitches and enable drops
    cur_a = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 5) == 0) cur_a[i] = ~cur_a[i];
      cur_en = ($urandom_range(0, 9) != 0);
      step(cur_a, cur_en, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
